// File: rtl/uart_transmitter.sv
// uart_transmitter: UART 16750 serial transmit engine.
// Shifts one character out on SOUT as start bit, 5-8 data bits LSB first,
// optional parity, and 1, 1.5 or 2 stop bits. Bit timing is 16 TXCLK ticks.
// Optional feature macro: UART_TX_BREAK_EN (BC forces SOUT low when defined).
module uart_transmitter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TXCLK,
    input  logic       TXSTART,
    input  logic       CLEAR,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    input  logic [7:0] DIN,
    output logic       TXFINISHED,
    output logic       SOUT
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        STOP2 = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] baud_q, baud_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       sout_q, sout_d;
    logic       fin_q, fin_d;

    logic [7:0] din_masked;
    logic       par_calc;
    logic       bit_step;
    logic       half_step;
    logic       last_bit;
    logic       fsm_sout;

    // Mask the character to the word length and derive the parity bit for it.
    always_comb begin
        case (WLS)
            2'b00:   din_masked = DIN & 8'h1F;
            2'b01:   din_masked = DIN & 8'h3F;
            2'b10:   din_masked = DIN & 8'h7F;
            default: din_masked = DIN;
        endcase
        if (SP) begin
            par_calc = ~EPS;
        end else if (EPS) begin
            par_calc = ^din_masked;
        end else begin
            par_calc = ~(^din_masked);
        end
    end

    // A full bit ends on the tick that wraps the counter; half a bit after 8 ticks.
    assign bit_step  = TXCLK && (baud_q == 4'd15);
    assign half_step = TXCLK && (baud_q == 4'd7);
    // Last data bit index is word length minus one, i.e. 4 + WLS.
    assign last_bit  = (bit_cnt_q == {1'b1, WLS});

    // Baud tick counter: held at zero while idle or being cleared.
    always_comb begin
        baud_d = baud_q;
        if (CLEAR || (state_q == IDLE)) begin
            baud_d = 4'd0;
        end else if (TXCLK) begin
            baud_d = baud_q + 4'd1;
        end
    end

    // Next-state, datapath and serial-line value for the frame sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        fin_d     = 1'b0;
        fsm_sout  = 1'b1;

        case (state_q)
            IDLE: begin
                if (TXSTART) begin
                    state_d   = START;
                    shift_d   = DIN;
                    par_d     = par_calc;
                    bit_cnt_d = 3'd0;
                end
            end
            START: begin
                fsm_sout = 1'b0;
                if (bit_step) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                fsm_sout = shift_q[0];
                if (bit_step) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        state_d = PEN ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                fsm_sout = par_q;
                if (bit_step) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_step) begin
                    if (STB) begin
                        state_d = STOP2;
                    end else begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                    end
                end
            end
            STOP2: begin
                // 5-bit words get a half-length second stop bit (1.5 total).
                if ((WLS == 2'b00) ? half_step : bit_step) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a start request in the same cycle.
        if (CLEAR) begin
            state_d  = IDLE;
            fin_d    = 1'b0;
            fsm_sout = 1'b1;
        end
    end

    // Output register source: break forces the line low when the feature is built in.
`ifdef UART_TX_BREAK_EN
    always_comb begin
        sout_d = BC ? 1'b0 : fsm_sout;
    end
`else
    logic unused_bc;
    assign unused_bc = BC;

    always_comb begin
        sout_d = fsm_sout;
    end
`endif

    // State and datapath registers; line idles high out of reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            baud_q    <= 4'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            sout_q    <= 1'b1;
            fin_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            sout_q    <= sout_d;
            fin_q     <= fin_d;
        end
    end

    assign SOUT       = sout_q;
    assign TXFINISHED = fin_q;

endmodule
